// File: rtl/mapping_group_accum.sv
// mapping_group_accum: weights NUM_CH encoded channel values by bit significance,
// sums them per beat and accumulates NUM_STEPS beats into a full-precision
// accumulator. In PARALLEL mode each beat is also shifted by its step index.
// Optional build macro: MAPPING_GROUP_ACC_SAT_EN (saturate result_o on overflow).
module mapping_group_accum #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned ENC_W        = 7,
  parameter int unsigned CH_SHIFT     = 2,
  parameter int unsigned NUM_STEPS    = 4,
  parameter int unsigned STEP_SHIFT   = 2,
  parameter int unsigned OUT_W        = 32,
  parameter logic [2:0]  PIM_PARALLEL = 3'b100,
  parameter logic [2:0]  PIM_RBR      = 3'b101,
  localparam int unsigned STEP_W      = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [2:0]              pim_mode_i,
  input  logic                    enc_valid_i,
  output logic                    enc_ready_o,
  input  logic [NUM_CH*ENC_W-1:0] enc_data_i,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic [OUT_W-1:0]        result_o,
  output logic                    busy_o,
  output logic [STEP_W-1:0]       step_o,
  output logic                    ovf_o
);

  localparam int unsigned SUM_W = ENC_W + CH_SHIFT*(NUM_CH-1) + $clog2(NUM_CH);
  localparam int unsigned ACC_W = SUM_W + STEP_SHIFT*(NUM_STEPS-1) + $clog2(NUM_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [2:0]         mode_q, mode_d;
  logic               ovf_q, ovf_d;

  logic [SUM_W-1:0]   beat_sum;
  logic [ACC_W-1:0]   acc_add;

  // Weighted channel sum; channel 0 sits in the MSBs and carries the largest weight.
  always_comb begin
    beat_sum = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      beat_sum += SUM_W'(enc_data_i[(NUM_CH-1-i)*ENC_W +: ENC_W]) << (CH_SHIFT*(NUM_CH-1-i));
    end
  end

  // Per-step addend: shifted by step significance only in parallel mode.
  always_comb begin
    if (mode_q == PIM_PARALLEL) acc_add = ACC_W'(beat_sum) << (step_q * STEP_SHIFT);
    else                        acc_add = ACC_W'(beat_sum);
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    step_d  = step_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && (pim_mode_i == PIM_PARALLEL || pim_mode_i == PIM_RBR)) begin
          mode_d  = pim_mode_i;
          acc_d   = '0;
          step_d  = '0;
          ovf_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (enc_valid_i) begin
          acc_d = acc_q + acc_add;
          ovf_d = ovf_q | (|(acc_d >> OUT_W));
          if (step_q == LAST_STEP) begin
            step_d  = '0;
            state_d = S_DONE;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (result_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d = S_IDLE;
      acc_d   = '0;
      step_d  = '0;
      ovf_d   = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      step_q  <= '0;
      mode_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status and result outputs; result follows the held accumulator.
  always_comb begin
    enc_ready_o    = (state_q == S_ACCUM);
    result_valid_o = (state_q == S_DONE);
    busy_o         = (state_q != S_IDLE);
    step_o         = step_q;
    ovf_o          = ovf_q;
`ifdef MAPPING_GROUP_ACC_SAT_EN
    result_o       = ovf_q ? '1 : OUT_W'(acc_q);
`else
    result_o       = OUT_W'(acc_q);
`endif
  end

endmodule

// File: tb/tb_mapping_group_accum.sv
// Bench for mapping_group_accum: default instance plus an OUT_W=16 instance
// sharing stimulus, checked against an arithmetic model of the mapping rules.
module tb_mapping_group_accum;

  localparam logic [2:0] PAR = 3'b100;
  localparam logic [2:0] RBR = 3'b101;
  localparam logic [27:0] ONES = {4{7'd1}};
  localparam logic [27:0] FULL = {4{7'd127}};
`ifdef MAPPING_GROUP_ACC_SAT_EN
  localparam longint FULL_PAR16 = 65535;
`else
  localparam longint FULL_PAR16 = 71;
`endif

  logic        clk = 1'b0;
  logic        rst_i, start_i, abort_i, enc_valid_i, result_ready_i;
  logic [2:0]  pim_mode_i;
  logic [27:0] enc_data_i;

  logic        enc_ready_o, result_valid_o, busy_o, ovf_o;
  logic [31:0] result_o;
  logic [1:0]  step_o;

  logic        rdy16, rv16, busy16, ovf16;
  logic [15:0] r16;
  logic [1:0]  step16;

  mapping_group_accum dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .pim_mode_i(pim_mode_i), .enc_valid_i(enc_valid_i), .enc_ready_o(enc_ready_o),
    .enc_data_i(enc_data_i), .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i), .result_o(result_o), .busy_o(busy_o),
    .step_o(step_o), .ovf_o(ovf_o)
  );

  mapping_group_accum #(.OUT_W(16)) dut16 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .pim_mode_i(pim_mode_i), .enc_valid_i(enc_valid_i), .enc_ready_o(rdy16),
    .enc_data_i(enc_data_i), .result_valid_o(rv16),
    .result_ready_i(result_ready_i), .result_o(r16), .busy_o(busy16),
    .step_o(step16), .ovf_o(ovf16)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  mode;
    logic [27:0] data;
    bit          gap;
    longint      exp32;
    longint      exp16;
    bit          eovf16;
  } vec_t;

  vec_t tbl[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: channel i weighs 4^(3-i); in parallel mode beat k weighs 4^k.
  function automatic longint ref_acc(input logic [2:0] mode, input logic [3:0][27:0] beats);
    longint acc = 0;
    for (int k = 0; k < 4; k++) begin
      longint s = 0;
      for (int i = 0; i < 4; i++) begin
        logic [6:0] ch = beats[k][(3-i)*7 +: 7];
        s += longint'(ch) * (longint'(4) ** (3-i));
      end
      acc += (mode == PAR) ? s * (longint'(4) ** k) : s;
    end
    return acc;
  endfunction

  function automatic longint ref_out16(input longint acc);
`ifdef MAPPING_GROUP_ACC_SAT_EN
    if (acc > 65535) return 65535;
`endif
    return acc % 65536;
  endfunction

  task automatic do_op(input string nm, input logic [2:0] mode, input logic [3:0][27:0] beats,
                       input bit gap, input int hold, input longint e32, input longint e16,
                       input bit eovf16);
    start_i = 1'b1;
    pim_mode_i = mode;
    tick();
    start_i = 1'b0;
    pim_mode_i = 3'($urandom);
    chk({nm, ".busy"}, longint'(busy_o), 1);
    for (int k = 0; k < 4; k++) begin
      if (gap) begin
        enc_valid_i = 1'b0;
        enc_data_i = 28'($urandom);
        tick();
      end
      chk({nm, ".step"}, longint'(step_o), k);
      chk({nm, ".ready"}, longint'(enc_ready_o), 1);
      enc_valid_i = 1'b1;
      enc_data_i = beats[k];
      tick();
      enc_valid_i = 1'b0;
      if (k < 3) chk({nm, ".early_valid"}, longint'(result_valid_o), 0);
    end
    chk({nm, ".valid"}, longint'(result_valid_o), 1);
    chk({nm, ".step_wrap"}, longint'(step_o), 0);
    chk({nm, ".result"}, longint'(result_o), e32);
    chk({nm, ".ovf"}, longint'(ovf_o), (e32 > 64'hFFFF_FFFF) ? 1 : 0);
    chk({nm, ".valid16"}, longint'(rv16), 1);
    chk({nm, ".result16"}, longint'(r16), e16);
    chk({nm, ".ovf16"}, longint'(ovf16), longint'(eovf16));
    for (int h = 0; h < hold; h++) begin
      enc_valid_i = 1'b1;
      enc_data_i = 28'($urandom);
      start_i = 1'b1;
      pim_mode_i = PAR;
      tick();
      chk({nm, ".hold_result"}, longint'(result_o), e32);
      chk({nm, ".hold_valid"}, longint'(result_valid_o), 1);
      chk({nm, ".hold_ready"}, longint'(enc_ready_o), 0);
      chk({nm, ".hold_result16"}, longint'(r16), e16);
    end
    enc_valid_i = 1'b0;
    start_i = 1'b0;
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    chk({nm, ".idle_busy"}, longint'(busy_o), 0);
    chk({nm, ".idle_valid"}, longint'(result_valid_o), 0);
  endtask

  initial begin
    logic [3:0][27:0] b;
    logic [2:0] m;
    longint e;

    tbl[0] = '{PAR, ONES, 1'b0, 7225,   7225,       1'b0};
    tbl[1] = '{RBR, ONES, 1'b0, 340,    340,        1'b0};
    tbl[2] = '{PAR, FULL, 1'b1, 917575, FULL_PAR16, 1'b1};
    tbl[3] = '{RBR, FULL, 1'b0, 43180,  43180,      1'b0};

    rst_i = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    enc_valid_i = 1'b0;
    result_ready_i = 1'b0;
    pim_mode_i = '0;
    enc_data_i = '0;
    tick();
    tick();
    chk("reset.result", longint'(result_o), 0);
    chk("reset.valid", longint'(result_valid_o), 0);
    chk("reset.ready", longint'(enc_ready_o), 0);
    chk("reset.busy", longint'(busy_o), 0);
    chk("reset.step", longint'(step_o), 0);
    chk("reset.ovf", longint'(ovf_o), 0);
    chk("reset.all16", longint'({r16, rv16, rdy16, busy16, step16, ovf16}), 0);
    rst_i = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      b = {4{tbl[v].data}};
      do_op($sformatf("tbl%0d", v), tbl[v].mode, b, tbl[v].gap, 0,
            tbl[v].exp32, tbl[v].exp16, tbl[v].eovf16);
    end

    // Abort after two beats, then a clean RBR run must show no residue.
    start_i = 1'b1;
    pim_mode_i = PAR;
    tick();
    start_i = 1'b0;
    enc_valid_i = 1'b1;
    enc_data_i = FULL;
    tick();
    tick();
    enc_valid_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort.busy", longint'(busy_o), 0);
    chk("abort.valid", longint'(result_valid_o), 0);
    chk("abort.step", longint'(step_o), 0);
    chk("abort.result", longint'(result_o), 0);
    b = {4{ONES}};
    do_op("after_abort", RBR, b, 1'b0, 0, 340, 340, 1'b0);

    // Unsupported mode and start-with-abort are both dropped.
    start_i = 1'b1;
    pim_mode_i = 3'b000;
    tick();
    start_i = 1'b0;
    chk("bad_mode.busy", longint'(busy_o), 0);
    chk("bad_mode.ready", longint'(enc_ready_o), 0);
    start_i = 1'b1;
    abort_i = 1'b1;
    pim_mode_i = PAR;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("abort_start.busy", longint'(busy_o), 0);

    // Result held across backpressure with stray beats and starts.
    b = {4{ONES}};
    do_op("hold", PAR, b, 1'b0, 5, 7225, 7225, 1'b0);

    // Asynchronous reset mid-accumulation clears outputs without a clock edge.
    start_i = 1'b1;
    pim_mode_i = PAR;
    tick();
    start_i = 1'b0;
    enc_valid_i = 1'b1;
    enc_data_i = FULL;
    tick();
    tick();
    enc_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("async_rst.result", longint'(result_o), 0);
    chk("async_rst.busy", longint'(busy_o), 0);
    chk("async_rst.step", longint'(step_o), 0);
    chk("async_rst.ready", longint'(enc_ready_o), 0);
    chk("async_rst.r16", longint'(r16), 0);
    tick();
    rst_i = 1'b0;
    tick();

    // Randomized operations against the reference.
    for (int r = 0; r < 25; r++) begin
      m = ($urandom_range(1) == 1) ? PAR : RBR;
      for (int k = 0; k < 4; k++) b[k] = 28'($urandom);
      e = ref_acc(m, b);
      do_op($sformatf("rand%0d", r), m, b, bit'($urandom_range(1)), int'($urandom_range(2)),
            e, ref_out16(e), (e > 65535));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
